// File: rtl/nap_countdown.sv
// Nap countdown timer: loads a BCD hh:mm:ss value, counts down on tick_1hz and raises an alarm at zero.
// Optional macro NAP_ALARM_TIMEOUT_EN auto-clears the alarm after ALARM_SECONDS ticks.
module nap_countdown #(
    parameter int ALARM_SECONDS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic       sharp,
    input  logic [3:0] hour_ten_in,
    input  logic [3:0] hour_one_in,
    input  logic [3:0] min_ten_in,
    input  logic [3:0] min_one_in,
    input  logic [3:0] sec_ten_in,
    input  logic [3:0] sec_one_in,
    output logic [3:0] hour_ten_out,
    output logic [3:0] hour_one_out,
    output logic [3:0] min_ten_out,
    output logic [3:0] min_one_out,
    output logic [3:0] sec_ten_out,
    output logic [3:0] sec_one_out,
    output logic       running,
    output logic       alarm,
    output logic       load_err
);

    typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;

    state_t     state;
    logic       valid_load;
    logic       load_zero;
    logic       dec_zero;
    logic [3:0] d_ht, d_ho, d_mt, d_mo, d_st, d_so;

    if (ALARM_SECONDS < 1) begin : g_param_check
        $error("ALARM_SECONDS must be at least 1");
    end

`ifdef NAP_ALARM_TIMEOUT_EN
    localparam int TW = $clog2(ALARM_SECONDS + 1);
    logic [TW-1:0] alarm_cnt;
`endif

    // Hour value must stay within 00..23 in addition to per-digit BCD limits.
    assign valid_load = (hour_ten_in <= 4'd2) && (hour_one_in <= 4'd9) &&
                        (min_ten_in <= 4'd5) && (min_one_in <= 4'd9) &&
                        (sec_ten_in <= 4'd5) && (sec_one_in <= 4'd9) &&
                        !((hour_ten_in == 4'd2) && (hour_one_in > 4'd3));

    assign load_zero = ({hour_ten_in, hour_one_in, min_ten_in,
                         min_one_in, sec_ten_in, sec_one_in} == 24'd0);

    always_comb begin
        d_ht = hour_ten_out;
        d_ho = hour_one_out;
        d_mt = min_ten_out;
        d_mo = min_one_out;
        d_st = sec_ten_out;
        d_so = sec_one_out;
        if (sec_one_out != 4'd0) begin
            d_so = sec_one_out - 4'd1;
        end else begin
            d_so = 4'd9;
            if (sec_ten_out != 4'd0) begin
                d_st = sec_ten_out - 4'd1;
            end else begin
                d_st = 4'd5;
                if (min_one_out != 4'd0) begin
                    d_mo = min_one_out - 4'd1;
                end else begin
                    d_mo = 4'd9;
                    if (min_ten_out != 4'd0) begin
                        d_mt = min_ten_out - 4'd1;
                    end else begin
                        d_mt = 4'd5;
                        if (hour_one_out != 4'd0) begin
                            d_ho = hour_one_out - 4'd1;
                        end else begin
                            d_ho = 4'd9;
                            d_ht = hour_ten_out - 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign dec_zero = ({d_ht, d_ho, d_mt, d_mo, d_st, d_so} == 24'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            hour_ten_out <= 4'd0;
            hour_one_out <= 4'd0;
            min_ten_out  <= 4'd0;
            min_one_out  <= 4'd0;
            sec_ten_out  <= 4'd0;
            sec_one_out  <= 4'd0;
            running      <= 1'b0;
            alarm        <= 1'b0;
            load_err     <= 1'b0;
`ifdef NAP_ALARM_TIMEOUT_EN
            alarm_cnt    <= '0;
`endif
        end else begin
            load_err <= 1'b0;
            if (load) begin
                // A load overrides sharp and tick in the same cycle, valid or not.
                if (valid_load) begin
                    hour_ten_out <= hour_ten_in;
                    hour_one_out <= hour_one_in;
                    min_ten_out  <= min_ten_in;
                    min_one_out  <= min_one_in;
                    sec_ten_out  <= sec_ten_in;
                    sec_one_out  <= sec_one_in;
                    if (load_zero) begin
                        state   <= ALARM;
                        running <= 1'b0;
                        alarm   <= 1'b1;
`ifdef NAP_ALARM_TIMEOUT_EN
                        alarm_cnt <= '0;
`endif
                    end else begin
                        state   <= RUN;
                        running <= 1'b1;
                        alarm   <= 1'b0;
                    end
                end else begin
                    load_err <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (sharp) begin
                            state        <= IDLE;
                            running      <= 1'b0;
                            hour_ten_out <= 4'd0;
                            hour_one_out <= 4'd0;
                            min_ten_out  <= 4'd0;
                            min_one_out  <= 4'd0;
                            sec_ten_out  <= 4'd0;
                            sec_one_out  <= 4'd0;
                        end else if (tick_1hz) begin
                            hour_ten_out <= d_ht;
                            hour_one_out <= d_ho;
                            min_ten_out  <= d_mt;
                            min_one_out  <= d_mo;
                            sec_ten_out  <= d_st;
                            sec_one_out  <= d_so;
                            if (dec_zero) begin
                                state   <= ALARM;
                                running <= 1'b0;
                                alarm   <= 1'b1;
`ifdef NAP_ALARM_TIMEOUT_EN
                                alarm_cnt <= '0;
`endif
                            end
                        end
                    end
                    ALARM: begin
                        if (sharp) begin
                            state <= IDLE;
                            alarm <= 1'b0;
`ifdef NAP_ALARM_TIMEOUT_EN
                        end else if (tick_1hz) begin
                            if (alarm_cnt == TW'(ALARM_SECONDS - 1)) begin
                                state <= IDLE;
                                alarm <= 1'b0;
                            end else begin
                                alarm_cnt <= alarm_cnt + 1'b1;
                            end
`endif
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/nap_countdown.md
NAP_COUNTDOWN -- requirements
Module: nap_countdown

Interface
REQ-001 Parameter ALARM_SECONDS, default 60: number of tick_1hz pulses the alarm stays asserted before auto-clear (used only with NAP_ALARM_TIMEOUT_EN).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-low.
REQ-004 tick_1hz  input  1  one-clk-wide enable pulse, once per second.
REQ-005 load  input  1  one-clk pulse; connected to completeSetting of the upstream shortcut setting stage.
REQ-006 sharp  input  1  keypad '#' pulse; cancel while running, acknowledge while alarming.
REQ-007 hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in  input  4 each  BCD nap end-time digits from the upstream stage.
REQ-008 hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out  output  4 each  remaining time, BCD, registered.
REQ-009 running  output  1  high in state RUN.
REQ-010 alarm  output  1  high in state ALARM.
REQ-011 load_err  output  1  one-clk pulse on a rejected load.

Function
REQ-012 States: IDLE, RUN, ALARM; all outputs registered; no combinational input-to-output path.
REQ-013 Valid load: every digit <= 9, sec_ten_in and min_ten_in <= 5, hour_ten_in <= 2, and hour value <= 23.
REQ-014 Valid load in any state: copy the six input digits into the counter.
REQ-015 After a valid load, the next state is RUN if the loaded value is non-zero and ALARM if it is 00:00:00.
REQ-016 A valid load on clk edge N shows the new digits and running/alarm on the outputs from edge N+1.
REQ-017 Invalid load: counter and state unchanged; load_err=1 for exactly one clk.
REQ-018 RUN and tick_1hz: decrement one second in BCD with borrow chain sec_one 0->9, sec_ten 0->5, min_one 0->9, min_ten 0->5, hour_one 0->9, hour_ten decrements.
REQ-019 A decrement that produces 00:00:00 moves the state to ALARM on the same edge; the counter does not decrement below 00:00:00.
REQ-020 load and tick_1hz in the same clk: load wins and no decrement occurs that clk.
REQ-021 load and sharp in the same clk: load wins.
REQ-022 RUN and sharp: go to IDLE and clear the counter to 00:00:00.
REQ-023 ALARM and sharp: go to IDLE; the counter stays at 00:00:00.
REQ-024 tick_1hz in IDLE and ALARM: does not change the counter.
REQ-025 running and alarm are never high together.

Reset
REQ-026 rst=0 sampled on a clk edge: state IDLE, all six digit outputs 0, running=0, alarm=0, load_err=0, alarm-timeout counter 0.
REQ-027 Reset takes priority over load, sharp and tick_1hz, including in mid-RUN and mid-ALARM.

Configuration
REQ-028 Macro NAP_ALARM_TIMEOUT_EN defined: ALARM counts tick_1hz pulses and returns to IDLE on the ALARM_SECONDS-th pulse; sharp still exits ALARM earlier.
REQ-029 Timeout counter width is clog2(ALARM_SECONDS+1); it clears on every entry to ALARM.
REQ-030 Macro NAP_ALARM_TIMEOUT_EN undefined: no timeout counter; ALARM is held until sharp, load or reset.

Verification
REQ-031 Load 00:00:05, then 5 ticks -> outputs step 4,3,2,1,0; alarm=1 and running=0 the clk after the 5th tick.
REQ-032 Load 01:00:00, then 1 tick -> output 00:59:59 with running=1.
REQ-033 Load with min_ten_in=6 -> single load_err pulse; state and digits unchanged.
REQ-034 In RUN, load and tick_1hz in the same clk -> outputs equal the new input digits with no decrement.
REQ-035 In RUN at 00:10:00, sharp -> IDLE, outputs 00:00:00; then rst=0 during ALARM -> IDLE on the next edge.
REQ-036 With NAP_ALARM_TIMEOUT_EN and ALARM_SECONDS=3: alarm clears the clk after the 3rd tick; without the macro, alarm is still high after 100 ticks.
